// File: rtl/aes_key_expander_pkg.sv
// Shared AES-128 constants for the key schedule: state encoding, round count, Rcon and S-box tables.
// Consumed by aes_key_expander (optional busy port under KEYGEN_BUSY_OUT_EN) and aes_sbox.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EXPAND = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int          RND_W = 4;
  localparam logic [3:0]  NR    = 4'd10;

  localparam logic [1:10][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Index 0 sits in the most significant byte of the first row.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] rcon_of(input logic [RND_W-1:0] k);
    if (k >= 4'd1 && k <= NR) begin
      rcon_of = RCON[k];
    end else begin
      rcon_of = 8'h00;
    end
  endfunction

endpackage

// File: rtl/aes_key_expander_if.sv
// Key-in / round-key-out bundle between the input interface, the key expander and the round transformer.
// The busy signal exists only when KEYGEN_BUSY_OUT_EN is defined.
interface aes_key_expander_if;
  logic [127:0] key_in;
  logic         key_start;
  logic         transformer_start;
  logic [127:0] round0_key, round1_key, round2_key, round3_key, round4_key, round5_key;
  logic [127:0] round6_key, round7_key, round8_key, round9_key, round10_key;
`ifdef KEYGEN_BUSY_OUT_EN
  logic         busy;

  modport master (
    output key_in, key_start,
    input  transformer_start, busy,
    input  round0_key, round1_key, round2_key, round3_key, round4_key, round5_key,
    input  round6_key, round7_key, round8_key, round9_key, round10_key
  );
  modport slave (
    input  key_in, key_start,
    output transformer_start, busy,
    output round0_key, round1_key, round2_key, round3_key, round4_key, round5_key,
    output round6_key, round7_key, round8_key, round9_key, round10_key
  );
`else
  modport master (
    output key_in, key_start,
    input  transformer_start,
    input  round0_key, round1_key, round2_key, round3_key, round4_key, round5_key,
    input  round6_key, round7_key, round8_key, round9_key, round10_key
  );
  modport slave (
    input  key_in, key_start,
    output transformer_start,
    output round0_key, round1_key, round2_key, round3_key, round4_key, round5_key,
    output round6_key, round7_key, round8_key, round9_key, round10_key
  );
`endif
endinterface

// File: rtl/aes_key_expander_sbox.sv
// Combinational AES forward S-box lookup; one byte in, one byte out.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);
  assign out_o = SBOX[in_i];
endmodule

// File: rtl/aes_key_expander.sv
// AES-128 key schedule: captures the cipher key, derives one round key per clock, then pulses transformer_start.
// Defining KEYGEN_BUSY_OUT_EN adds a registered busy output that is high outside IDLE.
module aes_key_expander
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst_,
  aes_key_expander_if.slave kif
);

  state_e           state_q, state_d;
  logic [RND_W-1:0] rnd_q, rnd_d;
  logic [127:0]     key_q [0:10];
  logic [127:0]     key_d [0:10];
  logic             tstart_q, tstart_d;
`ifdef KEYGEN_BUSY_OUT_EN
  logic             busy_q, busy_d;
`endif

  logic [RND_W-1:0] prev_idx_s;
  logic [127:0]     prev_s, next_s;
  logic [31:0]      rot_s, sub_s, t_s, n0_s, n1_s, n2_s, n3_s;

  // Round k is derived from round k-1; the counter always names the key being written.
  assign prev_idx_s = (rnd_q >= 4'd1 && rnd_q <= NR) ? (rnd_q - 4'd1) : 4'd0;
  assign prev_s     = key_q[prev_idx_s];
  assign rot_s      = {prev_s[23:0], prev_s[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (.in_i(rot_s[8*i +: 8]), .out_o(sub_s[8*i +: 8]));
  end

  assign t_s    = sub_s ^ {rcon_of(rnd_q), 24'h000000};
  assign n0_s   = prev_s[127:96] ^ t_s;
  assign n1_s   = prev_s[95:64]  ^ n0_s;
  assign n2_s   = prev_s[63:32]  ^ n1_s;
  assign n3_s   = prev_s[31:0]   ^ n2_s;
  assign next_s = {n0_s, n1_s, n2_s, n3_s};

  always_comb begin
    state_d  = state_q;
    rnd_d    = rnd_q;
    tstart_d = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      key_d[k] = key_q[k];
    end
    case (state_q)
      IDLE: begin
        if (kif.key_start) begin
          state_d  = LOAD;
          key_d[0] = kif.key_in;
          rnd_d    = 4'd1;
        end else begin
          state_d  = IDLE;
        end
      end
      LOAD, EXPAND: begin
        for (int k = 1; k <= 10; k++) begin
          if (rnd_q == 4'(k)) begin
            key_d[k] = next_s;
          end else begin
            key_d[k] = key_q[k];
          end
        end
        if (rnd_q == NR) begin
          state_d  = DONE;
          tstart_d = 1'b1;
          rnd_d    = 4'd0;
        end else begin
          state_d  = EXPAND;
          rnd_d    = rnd_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef KEYGEN_BUSY_OUT_EN
    busy_d = (state_d != IDLE);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q  <= IDLE;
      rnd_q    <= 4'd0;
      tstart_q <= 1'b0;
      for (int k = 0; k <= 10; k++) begin
        key_q[k] <= 128'h0;
      end
`ifdef KEYGEN_BUSY_OUT_EN
      busy_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rnd_q    <= rnd_d;
      tstart_q <= tstart_d;
      for (int k = 0; k <= 10; k++) begin
        key_q[k] <= key_d[k];
      end
`ifdef KEYGEN_BUSY_OUT_EN
      busy_q   <= busy_d;
`endif
    end
  end

  assign kif.transformer_start = tstart_q;
  assign kif.round0_key  = key_q[0];
  assign kif.round1_key  = key_q[1];
  assign kif.round2_key  = key_q[2];
  assign kif.round3_key  = key_q[3];
  assign kif.round4_key  = key_q[4];
  assign kif.round5_key  = key_q[5];
  assign kif.round6_key  = key_q[6];
  assign kif.round7_key  = key_q[7];
  assign kif.round8_key  = key_q[8];
  assign kif.round9_key  = key_q[9];
  assign kif.round10_key = key_q[10];
`ifdef KEYGEN_BUSY_OUT_EN
  assign kif.busy = busy_q;
`endif

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander: FIPS-197 and zero-key schedules, restart/ignore and reset-abort cases.
// Busy timing is also checked when KEYGEN_BUSY_OUT_EN is defined.
module tb_aes_key_expander;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] OTHER    = 128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0;
  logic rst_;
  int   vectors = 0;
  int   miscompares = 0;

  aes_key_expander_if kif ();
  aes_key_expander u_dut (.clk(clk), .rst_(rst_), .kif(kif.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] key_of(input int i);
    case (i)
      0:  return kif.round0_key;
      1:  return kif.round1_key;
      2:  return kif.round2_key;
      3:  return kif.round3_key;
      4:  return kif.round4_key;
      5:  return kif.round5_key;
      6:  return kif.round6_key;
      7:  return kif.round7_key;
      8:  return kif.round8_key;
      9:  return kif.round9_key;
      10: return kif.round10_key;
      default: return 128'h0;
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    for (int i = 0; i <= 10; i++) begin
      check($sformatf("%s_round%0d", tag, i), key_of(i), 128'h0);
    end
    check({tag, "_tstart"}, {127'h0, kif.transformer_start}, 128'h0);
`ifdef KEYGEN_BUSY_OUT_EN
    check({tag, "_busy"}, {127'h0, kif.busy}, 128'h0);
`endif
  endtask

  // Leaves the bench at the falling edge right after the sampling edge T.
  task automatic start_pulse(input logic [127:0] key);
    @(negedge clk);
    kif.key_in    = key;
    kif.key_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    kif.key_start = 1'b0;
    kif.key_in    = ~key;
`ifdef KEYGEN_BUSY_OUT_EN
    check("busy_after_start", {127'h0, kif.busy}, 128'h1);
`endif
  endtask

  // Watches n further cycles; expect_at = cycle where the pulse must appear (0 = never).
  task automatic watch(input string tag, input int expect_at, input int n);
    int seen  = 0;
    int highs = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (kif.transformer_start === 1'b1) begin
        highs++;
        if (seen == 0) seen = k;
      end
`ifdef KEYGEN_BUSY_OUT_EN
      if (expect_at > 0 && k == expect_at) check({tag, "_busy_hi"}, {127'h0, kif.busy}, 128'h1);
      if (k == expect_at + 1) check({tag, "_busy_lo"}, {127'h0, kif.busy}, 128'h0);
`endif
    end
    check({tag, "_pulse_at"}, 128'(seen), 128'(expect_at));
    check({tag, "_pulse_cnt"}, 128'(highs), (expect_at > 0) ? 128'h1 : 128'h0);
  endtask

  initial begin
    rst_          = 1'b1;
    kif.key_start = 1'b1;
    kif.key_in    = FIPS_KEY;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_          = 1'b0;
    kif.key_start = 1'b0;
    @(negedge clk);
    check("post_reset_round0", kif.round0_key, 128'h0);

    start_pulse(FIPS_KEY);
    watch("fips", 10, 14);
    check("fips_round0", kif.round0_key, FIPS_KEY);
    check("fips_round1", kif.round1_key, FIPS_R1);
    check("fips_round2", kif.round2_key, FIPS_R2);
    check("fips_round10", kif.round10_key, FIPS_R10);

    start_pulse(128'h0);
    watch("zero", 10, 14);
    check("zero_round0", kif.round0_key, 128'h0);
    check("zero_round1", kif.round1_key, ZERO_R1);
    check("zero_round2", kif.round2_key, ZERO_R2);
    check("zero_round10", kif.round10_key, ZERO_R10);

    start_pulse(FIPS_KEY);
    repeat (4) @(negedge clk);
    kif.key_in    = OTHER;
    kif.key_start = 1'b1;
    @(negedge clk);
    kif.key_start = 1'b0;
    watch("ignore", 5, 9);
    check("ignore_round0", kif.round0_key, FIPS_KEY);
    check("ignore_round1", kif.round1_key, FIPS_R1);
    check("ignore_round10", kif.round10_key, FIPS_R10);

    start_pulse(128'h0);
    watch("restart", 10, 14);
    check("restart_round1", kif.round1_key, ZERO_R1);
    check("restart_round10", kif.round10_key, ZERO_R10);

    start_pulse(FIPS_KEY);
    repeat (3) @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
    rst_ = 1'b0;
    check_all_zero("abort");
    watch("abort", 0, 12);
    check("abort_round1_after", kif.round1_key, 128'h0);

    start_pulse(FIPS_KEY);
    watch("fresh", 10, 14);
    check("fresh_round1", kif.round1_key, FIPS_R1);
    check("fresh_round10", kif.round10_key, FIPS_R10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
